// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Byte-write strobe and status bundle of the UART transmit FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
) ();
  logic            tx_en;
  logic [7:0]      tx_data;
  logic            txd;
  logic            tx_busy;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ADDR_W:0] fifo_count;
  logic            overflow;

  modport master (
    output tx_en, tx_data,
    input  txd, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
  );

  modport slave (
    input  tx_en, tx_data,
    output txd, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO fed by one-cycle write strobes, drained onto txd as 8N1.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int                   c_baud_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_baud_w-1:0]  c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]      c_depth     = (ADDR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_start = 2'd1;
  localparam logic [1:0] c_data  = 2'd2;
  localparam logic [1:0] c_stop  = 2'd3;

  logic [1:0]          r_state,   w_state_nxt;
  logic [c_baud_w-1:0] r_baud,    w_baud_nxt;
  logic [2:0]          r_bit_idx, w_bit_idx_nxt;
  logic [7:0]          r_shift,   w_shift_nxt;
  logic                r_txd,     w_txd_nxt;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;
  logic                w_push, w_pop, w_bit_done;

  // Full test looks at the registered count, so a same-cycle pop never frees a slot.
  assign w_push     = bus.tx_en && (r_count != c_depth);
  assign w_bit_done = (r_baud == c_baud_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      if (bus.tx_en && !w_push) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    case (r_state)
      c_idle: begin
        if (r_count != '0) begin
          w_shift_nxt = r_mem[r_rd_ptr];
          w_baud_nxt  = '0;
          w_state_nxt = c_start;
        end
      end
      c_start: begin
        if (w_bit_done) begin
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = c_data;
        end else begin
          w_baud_nxt = r_baud + c_baud_w'(1);
        end
      end
      c_data: begin
        if (w_bit_done) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = c_stop;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + c_baud_w'(1);
        end
      end
      c_stop: begin
        if (w_bit_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = c_idle;
        end else begin
          w_baud_nxt = r_baud + c_baud_w'(1);
        end
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  // txd is registered from the next state so the line level lines up with the state.
  always_comb begin
    w_pop     = (r_state == c_idle) && (r_count != '0);
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      c_start: w_txd_nxt = 1'b0;
      c_data:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  assign bus.txd        = r_txd;
  assign bus.tx_busy    = (r_state != c_idle) || (r_count != '0);
  assign bus.fifo_full  = (r_count == c_depth);
  assign bus.fifo_empty = (r_count == '0);
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Scenario tasks plus a randomized run against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic       line_log [$];
  logic [7:0] decoded  [$];

  uart_tx_fifo_if #(.ADDR_W(AW)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_rec();
    tick();
    line_log.push_back(bus.txd);
  endtask

  task automatic do_reset();
    bus.tx_en = 1'b0;
    rst_n     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    line_log.delete();
    line_log.push_back(bus.txd);
  endtask

  // Recovers bytes from the recorded line by sampling the middle of every bit.
  task automatic decode_line();
    int i = 0;
    logic [7:0] b;
    decoded.delete();
    while (i + FRAME <= line_log.size()) begin
      if (line_log[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = line_log[i + CPB * (k + 1) + CPB / 2];
        decoded.push_back(b);
        i = i + 9 * CPB + CPB / 2;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    bus.tx_en = 1'b1; bus.tx_data = 8'h3C;
    tick();
    bus.tx_en = 1'b0;
    repeat (12) tick();
    rst_n = 1'b0; bus.tx_en = 1'b1; bus.tx_data = 8'hFF;
    repeat (3) tick();
    checks++; if (bus.txd !== 1'b1)        begin errors++; $display("FAIL rst_txd got %b want 1", bus.txd); end
    checks++; if (bus.tx_busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b want 0", bus.tx_busy); end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", bus.fifo_empty); end
    checks++; if (bus.fifo_full !== 1'b0)  begin errors++; $display("FAIL rst_full got %b want 0", bus.fifo_full); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b0)   begin errors++; $display("FAIL rst_ovf got %b want 0", bus.overflow); end
    bus.tx_en = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_release_count got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_single_byte();
    logic [7:0] v = 8'hA5;
    logic exp_txd, exp_busy;
    do_reset();
    bus.tx_en = 1'b1; bus.tx_data = v;
    for (int c = 1; c <= 46; c++) begin
      tick();
      bus.tx_en = 1'b0;
      if (c >= 2 && c <= 5)       exp_txd = 1'b0;
      else if (c >= 6 && c <= 37) exp_txd = v[(c - 6) / CPB];
      else                        exp_txd = 1'b1;
      exp_busy = (c <= 41);
      checks++; if (bus.txd !== exp_txd)     begin errors++; $display("FAIL single_txd cycle %0d got %b want %b", c, bus.txd, exp_txd); end
      checks++; if (bus.tx_busy !== exp_busy) begin errors++; $display("FAIL single_busy cycle %0d got %b want %b", c, bus.tx_busy, exp_busy); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    exp_q = '{8'h55, 8'h0F};
    do_reset();
    for (int c = 0; c <= 90; c++) begin
      if (c >= 2 && c <= 42) begin
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count cycle %0d got %0d want 1", c, bus.fifo_count); end
      end
      if (c == 42) begin
        checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL b2b_gap got %b want 1", bus.txd); end
      end
      if (c == 43) begin
        checks++; if (bus.txd !== 1'b0) begin errors++; $display("FAIL b2b_start2 got %b want 0", bus.txd); end
      end
      bus.tx_en   = (c <= 1);
      bus.tx_data = (c == 0) ? 8'h55 : 8'h0F;
      tick_rec();
    end
    bus.tx_en = 1'b0;
    decode_line();
    checks++; if (decoded.size() != exp_q.size()) begin errors++; $display("FAIL b2b_frames got %0d want %0d", decoded.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < decoded.size(); k++) begin
      checks++; if (decoded[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", k, decoded[k], exp_q[k]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c <= 230; c++) begin
      if (c == 2) begin
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL ovf_count2 got %0d want 1", bus.fifo_count); end
      end
      if (c == 5) begin
        checks++; if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", bus.fifo_full); end
        checks++; if (bus.overflow !== 1'b0)  begin errors++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
      end
      if (c == 6 || c == 230) begin
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky cycle %0d got %b want 1", c, bus.overflow); end
      end
      bus.tx_en   = (c <= 5);
      bus.tx_data = 8'(c);
      tick_rec();
    end
    bus.tx_en = 1'b0;
    decode_line();
    checks++; if (decoded.size() != 5) begin errors++; $display("FAIL ovf_frames got %0d want 5", decoded.size()); end
    for (int k = 0; k < 5 && k < decoded.size(); k++) begin
      checks++; if (decoded[k] !== 8'(k)) begin errors++; $display("FAIL ovf_byte%0d got %h want %h", k, decoded[k], 8'(k)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int c = 0; c <= 120; c++) begin
      if (c == 20) begin
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL midrst_pre_count got %0d want 1", bus.fifo_count); end
      end
      if (c == 21) begin
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", bus.fifo_count); end
      end
      if (c >= 21) begin
        checks++; if (bus.txd !== 1'b1) begin errors++; $display("FAIL midrst_txd cycle %0d got %b want 1", c, bus.txd); end
      end
      if (c >= 23) begin
        checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy cycle %0d got %b want 0", c, bus.tx_busy); end
      end
      rst_n       = !(c >= 20 && c <= 22);
      bus.tx_en   = (c <= 1);
      bus.tx_data = (c == 0) ? 8'h81 : 8'h7E;
      tick_rec();
    end
    rst_n = 1'b1; bus.tx_en = 1'b0;
  endtask

  task automatic test_full_and_popping();
    logic [7:0] exp_q [$];
    exp_q = '{8'hC3, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
    do_reset();
    for (int c = 0; c <= 215; c++) begin
      if (c == 41) begin
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL fp_fill got %0d want 4", bus.fifo_count); end
      end
      if (c == 42) begin
        checks++; if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL fp_full got %b want 1", bus.fifo_full); end
        checks++; if (bus.overflow !== 1'b0)  begin errors++; $display("FAIL fp_ovf_pre got %b want 0", bus.overflow); end
      end
      if (c == 43) begin
        checks++; if (bus.overflow !== 1'b1)   begin errors++; $display("FAIL fp_ovf got %b want 1", bus.overflow); end
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL fp_count got %0d want 3", bus.fifo_count); end
        checks++; if (bus.txd !== 1'b0)        begin errors++; $display("FAIL fp_start got %b want 0", bus.txd); end
      end
      bus.tx_en   = (c == 0) || (c >= 37 && c <= 40) || (c == 42);
      bus.tx_data = (c == 0) ? 8'hC3 : (c == 42) ? 8'hEE : 8'(8'hF0 + (c - 37));
      tick_rec();
    end
    bus.tx_en = 1'b0;
    decode_line();
    checks++; if (decoded.size() != exp_q.size()) begin errors++; $display("FAIL fp_frames got %0d want %0d", decoded.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < decoded.size(); k++) begin
      checks++; if (decoded[k] !== exp_q[k]) begin errors++; $display("FAIL fp_byte%0d got %h want %h", k, decoded[k], exp_q[k]); end
    end
  endtask

  // Model: a byte queue plus the cycle the transmitter is next free (each frame FRAME cycles).
  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] sent [$];
    int free_at = 0;
    int sz, pct;
    logic ovf = 1'b0;
    logic en;
    logic [7:0] d;
    logic [AW:0] exp_cnt;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      sz      = q.size();
      exp_cnt = sz[AW:0];
      checks++; if (bus.fifo_count !== exp_cnt)           begin errors++; $display("FAIL rnd_count cycle %0d got %0d want %0d", c, bus.fifo_count, exp_cnt); end
      checks++; if (bus.fifo_full !== (sz == DEPTH))      begin errors++; $display("FAIL rnd_full cycle %0d got %b want %b", c, bus.fifo_full, (sz == DEPTH)); end
      checks++; if (bus.overflow !== ovf)                 begin errors++; $display("FAIL rnd_ovf cycle %0d got %b want %b", c, bus.overflow, ovf); end
      checks++; if (bus.tx_busy !== (sz > 0 || c < free_at)) begin errors++; $display("FAIL rnd_busy cycle %0d got %b want %b", c, bus.tx_busy, (sz > 0 || c < free_at)); end
      pct = (c < 300) ? 4 : (c < 450) ? 45 : 0;
      en  = ($urandom_range(0, 99) < pct);
      d   = 8'($urandom);
      bus.tx_en = en; bus.tx_data = d;
      if (c >= free_at && sz > 0) begin
        sent.push_back(q.pop_front());
        free_at = c + 1 + FRAME;
      end
      if (en) begin
        if (sz < DEPTH) q.push_back(d);
        else            ovf = 1'b1;
      end
      tick_rec();
    end
    bus.tx_en = 1'b0;
    decode_line();
    checks++; if (decoded.size() != sent.size()) begin errors++; $display("FAIL rnd_frames got %0d want %0d", decoded.size(), sent.size()); end
    for (int k = 0; k < sent.size() && k < decoded.size(); k++) begin
      checks++; if (decoded[k] !== sent[k]) begin errors++; $display("FAIL rnd_byte%0d got %h want %h", k, decoded[k], sent[k]); end
    end
  endtask

  initial begin
    bus.tx_en   = 1'b0;
    bus.tx_data = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_full_and_popping();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
